// File: rtl/alu_pc_core.sv
// Execute-stage core of the single-cycle MIPS: PC register, PC+4 and branch-target
// adders, integer ALU, branch condition, and the HI/LO multiply/divide registers.
module alu_pc_core #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] pc_in,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rt_field,
  input  logic [15:0] immediate,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target,
  output logic        branch_taken,
  output logic [31:0] alu_result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_JAL   = 6'h03,
                         OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06,
                         OP_BGTZ    = 6'h07, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A,
                         OP_SLTIU   = 6'h0B, OP_ANDI   = 6'h0C, OP_ORI   = 6'h0D,
                         OP_XORI    = 6'h0E, OP_LUI    = 6'h0F, OP_LB    = 6'h20,
                         OP_LH      = 6'h21, OP_LW     = 6'h23, OP_LBU   = 6'h24,
                         OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29,
                         OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA   = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR    = 6'h08, F_JALR = 6'h09,
                         F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO  = 6'h12, F_MTLO = 6'h13,
                         F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU = 6'h1B,
                         F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND   = 6'h24, F_OR   = 6'h25,
                         F_XOR  = 6'h26, F_SLT  = 6'h2A, F_SLTU  = 6'h2B;

  logic [31:0] imm_sext, imm_zext, link_addr;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic        rs_neg, rs_zero, div_ok;
  logic        hi_we, lo_we;
  logic [31:0] hi_nxt, lo_nxt;

  assign imm_sext      = {{16{immediate[15]}}, immediate};
  assign imm_zext      = {16'h0000, immediate};
  assign pc_plus4      = pc_out + 32'd4;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign link_addr     = pc_out + 32'd8;

  assign prod_s = {{32{rs_content[31]}}, rs_content} * {{32{rt_content[31]}}, rt_content};
  assign prod_u = {32'h0, rs_content} * {32'h0, rt_content};
  // Division results are only committed when the divisor is nonzero.
  assign quot_s = $signed(rs_content) / $signed(rt_content);
  assign rem_s  = $signed(rs_content) % $signed(rt_content);
  assign quot_u = rs_content / rt_content;
  assign rem_u  = rs_content % rt_content;
  assign div_ok = (rt_content != 32'h0);

  assign rs_neg  = rs_content[31];
  assign rs_zero = (rs_content == 32'h0);

  always_comb begin
    alu_result   = 32'h0;
    branch_taken = 1'b0;
    hi_we        = 1'b0;
    lo_we        = 1'b0;
    hi_nxt       = hi;
    lo_nxt       = lo;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          F_SLL:   alu_result = rt_content << shamt;
          F_SRL:   alu_result = rt_content >> shamt;
          F_SRA:   alu_result = $signed(rt_content) >>> shamt;
          F_SLLV:  alu_result = rt_content << rs_content[4:0];
          F_SRLV:  alu_result = rt_content >> rs_content[4:0];
          F_SRAV:  alu_result = $signed(rt_content) >>> rs_content[4:0];
          F_ADDU:  alu_result = rs_content + rt_content;
          F_SUBU:  alu_result = rs_content - rt_content;
          F_AND:   alu_result = rs_content & rt_content;
          F_OR:    alu_result = rs_content | rt_content;
          F_XOR:   alu_result = rs_content ^ rt_content;
          F_SLT:   alu_result = {31'h0, $signed(rs_content) < $signed(rt_content)};
          F_SLTU:  alu_result = {31'h0, rs_content < rt_content};
          F_MFHI:  alu_result = hi;
          F_MFLO:  alu_result = lo;
          F_JR, F_JALR: alu_result = link_addr;
          F_MTHI: begin
            hi_we  = 1'b1;
            hi_nxt = rs_content;
          end
          F_MTLO: begin
            lo_we  = 1'b1;
            lo_nxt = rs_content;
          end
          F_MULT: begin
            hi_we  = 1'b1;
            lo_we  = 1'b1;
            hi_nxt = prod_s[63:32];
            lo_nxt = prod_s[31:0];
          end
          F_MULTU: begin
            hi_we  = 1'b1;
            lo_we  = 1'b1;
            hi_nxt = prod_u[63:32];
            lo_nxt = prod_u[31:0];
          end
          F_DIV: begin
            hi_we  = div_ok;
            lo_we  = div_ok;
            hi_nxt = rem_s;
            lo_nxt = quot_s;
          end
          F_DIVU: begin
            hi_we  = div_ok;
            lo_we  = div_ok;
            hi_nxt = rem_u;
            lo_nxt = quot_u;
          end
          default: ;
        endcase
      end
      OP_ADDIU: alu_result = rs_content + imm_sext;
      OP_SLTI:  alu_result = {31'h0, $signed(rs_content) < $signed(imm_sext)};
      OP_SLTIU: alu_result = {31'h0, rs_content < imm_sext};
      OP_ANDI:  alu_result = rs_content & imm_zext;
      OP_ORI:   alu_result = rs_content | imm_zext;
      OP_XORI:  alu_result = rs_content ^ imm_zext;
      OP_LUI:   alu_result = {immediate, 16'h0000};
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW: alu_result = rs_content + imm_sext;
      OP_JAL:   alu_result = link_addr;
      OP_BEQ:   branch_taken = (rs_content == rt_content);
      OP_BNE:   branch_taken = (rs_content != rt_content);
      OP_BLEZ:  branch_taken = rs_neg | rs_zero;
      OP_BGTZ:  branch_taken = ~rs_neg & ~rs_zero;
      OP_REGIMM: begin
        // rt_field[4] selects the linking variants, rt_field[0] picks >=0 vs <0.
        case (rt_field)
          5'h00: branch_taken = rs_neg;
          5'h01: branch_taken = ~rs_neg;
          5'h10: begin
            branch_taken = rs_neg;
            alu_result   = link_addr;
          end
          5'h11: begin
            branch_taken = ~rs_neg;
            alu_result   = link_addr;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out <= RESET_VECTOR;
      hi     <= 32'h0;
      lo     <= 32'h0;
    end else if (clk_enable) begin
      pc_out <= pc_in;
      if (hi_we) hi <= hi_nxt;
      if (lo_we) lo <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_alu_pc_core.sv
// Randomized self-checking bench for alu_pc_core against an integer-arithmetic
// reference model of the PC, HI/LO and ALU behaviour.
module tb_alu_pc_core;

  logic        clk = 1'b0;
  logic        reset, clk_enable;
  logic [31:0] pc_in, rs_content, rt_content;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt, rt_field;
  logic [15:0] immediate;
  logic [31:0] pc_out, pc_plus4, branch_target, alu_result, hi, lo;
  logic        branch_taken;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_pc, m_hi, m_lo;

  always #5 clk = ~clk;

  alu_pc_core dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .pc_in(pc_in),
    .opcode(opcode), .funct(funct), .shamt(shamt), .rt_field(rt_field),
    .immediate(immediate), .rs_content(rs_content), .rt_content(rt_content),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .branch_target(branch_target),
    .branch_taken(branch_taken), .alu_result(alu_result), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (op=%02h fn=%02h rs=%08h rt=%08h imm=%04h)",
                  tag, obs, exp, opcode, funct, rs_content, rt_content, immediate);
  endtask

  // Returns {taken, alu_result} computed from the instruction rules.
  function automatic logic [32:0] model_comb();
    int          a    = rs_content;
    int          b    = rt_content;
    int          se   = int'(shortint'(immediate));
    logic [31:0] ze   = 32'(immediate);
    logic [31:0] link = m_pc + 32'd8;
    logic [31:0] r    = 0;
    logic        t    = 0;
    case (opcode)
      6'h00: case (funct)
        6'h00: r = rt_content << shamt;
        6'h02: r = rt_content >> shamt;
        6'h03: r = b >>> shamt;
        6'h04: r = rt_content << rs_content[4:0];
        6'h06: r = rt_content >> rs_content[4:0];
        6'h07: r = b >>> rs_content[4:0];
        6'h21: r = a + b;
        6'h23: r = a - b;
        6'h24: r = rs_content & rt_content;
        6'h25: r = rs_content | rt_content;
        6'h26: r = rs_content ^ rt_content;
        6'h2A: r = (a < b) ? 1 : 0;
        6'h2B: r = (rs_content < rt_content) ? 1 : 0;
        6'h10: r = m_hi;
        6'h12: r = m_lo;
        6'h08, 6'h09: r = link;
        default: r = 0;
      endcase
      6'h09: r = a + se;
      6'h0A: r = (a < se) ? 1 : 0;
      6'h0B: r = (rs_content < 32'(se)) ? 1 : 0;
      6'h0C: r = rs_content & ze;
      6'h0D: r = rs_content | ze;
      6'h0E: r = rs_content ^ ze;
      6'h0F: r = ze * 65536;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: r = a + se;
      6'h03: r = link;
      6'h04: t = (a == b);
      6'h05: t = (a != b);
      6'h06: t = (a <= 0);
      6'h07: t = (a > 0);
      6'h01: begin
        if (rt_field == 5'h00 || rt_field == 5'h10) t = (a < 0);
        if (rt_field == 5'h01 || rt_field == 5'h11) t = (a >= 0);
        if (rt_field == 5'h10 || rt_field == 5'h11) r = link;
      end
      default: ;
    endcase
    return {t, r};
  endfunction

  task automatic drive(input logic rst, en, input logic [31:0] pcin, input logic [5:0] op, fn,
                       input logic [4:0] sh, rtf, input logic [15:0] imm,
                       input logic [31:0] rs, rt);
    reset = rst; clk_enable = en; pc_in = pcin; opcode = op; funct = fn;
    shamt = sh; rt_field = rtf; immediate = imm; rs_content = rs; rt_content = rt;
    #1;
  endtask

  task automatic check_comb();
    logic [32:0] e = model_comb();
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("branch_target", branch_target, m_pc + 32'd4 + 32'(int'(shortint'(immediate)) * 4));
    check("branch_taken", 32'(branch_taken), 32'(e[32]));
    check("alu_result", alu_result, e[31:0]);
  endtask

  task automatic tick();
    int          a = rs_content;
    int          b = rt_content;
    logic [63:0] p;
    longint      q, rm;
    @(posedge clk);
    if (reset) begin
      m_pc = 32'hBFC00000; m_hi = 0; m_lo = 0;
    end else if (clk_enable) begin
      m_pc = pc_in;
      if (opcode == 6'h00) case (funct)
        6'h11: m_hi = rs_content;
        6'h13: m_lo = rs_content;
        6'h18: begin p = longint'(a) * longint'(b); m_hi = p[63:32]; m_lo = p[31:0]; end
        6'h19: begin p = 64'(rs_content) * 64'(rt_content); m_hi = p[63:32]; m_lo = p[31:0]; end
        6'h1A: if (b != 0) begin
          q = longint'(a) / longint'(b); rm = longint'(a) % longint'(b);
          m_lo = q[31:0]; m_hi = rm[31:0];
        end
        6'h1B: if (b != 0) begin m_lo = rs_content / rt_content; m_hi = rs_content % rt_content; end
        default: ;
      endcase
    end
    #1;
    check("pc_out", pc_out, m_pc);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  task automatic run(input logic rst, en, input logic [31:0] pcin, input logic [5:0] op, fn,
                     input logic [4:0] sh, rtf, input logic [15:0] imm,
                     input logic [31:0] rs, rt);
    drive(rst, en, pcin, op, fn, sh, rtf, imm, rs, rt);
    check_comb();
    tick();
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] r_fn [23] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23, 6'h24,
                            6'h25, 6'h26, 6'h2A, 6'h2B, 6'h10, 6'h12, 6'h11, 6'h13, 6'h18,
                            6'h19, 6'h1A, 6'h1B, 6'h08, 6'h09};
  logic [5:0] i_op [21] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21,
                            6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h03, 6'h04, 6'h05,
                            6'h06, 6'h07, 6'h01};
  logic [4:0] rim  [4]  = '{5'h00, 5'h01, 5'h10, 5'h11};

  initial begin
    logic [5:0]  op, fn;
    logic [4:0]  rtf;
    logic [31:0] rs, rt;

    // Reset and enable gating
    drive(1, 0, 32'h0, 6'h00, 6'h00, 0, 0, 16'h0, 0, 0);
    tick();
    check("reset_pc", pc_out, 32'hBFC00000);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    run(0, 0, 32'hBFC00004, 6'h00, 6'h00, 0, 0, 16'h0, 0, 0);
    run(0, 0, 32'hBFC00004, 6'h00, 6'h00, 0, 0, 16'h0, 0, 0);
    check("enable_hold", pc_out, 32'hBFC00000);
    run(0, 1, 32'hBFC00004, 6'h00, 6'h00, 0, 0, 16'h0, 0, 0);
    check("enable_load", pc_out, 32'hBFC00004);

    // Branch target with negative offset
    run(1, 0, 32'h0, 6'h00, 6'h00, 0, 0, 16'h0, 0, 0);
    drive(0, 0, 32'h0, 6'h04, 6'h00, 0, 0, 16'hFFFF, 5, 5);
    check("beq_plus4", pc_plus4, 32'hBFC00004);
    check("beq_target", branch_target, 32'hBFC00000);
    check("beq_taken", 32'(branch_taken), 32'h1);
    check_comb(); tick();
    drive(0, 0, 32'h0, 6'h04, 6'h00, 0, 0, 16'hFFFF, 5, 6);
    check("beq_not_taken", 32'(branch_taken), 32'h0);
    check_comb(); tick();

    // ALU spot values
    drive(0, 0, 0, 6'h09, 0, 0, 0, 16'h0001, 32'hFFFFFFFF, 0);
    check("addiu_wrap", alu_result, 32'h0); check_comb(); tick();
    drive(0, 0, 0, 6'h00, 6'h03, 4, 0, 0, 0, 32'h80000000);
    check("sra", alu_result, 32'hF8000000); check_comb(); tick();
    drive(0, 0, 0, 6'h00, 6'h2B, 0, 0, 0, 1, 32'hFFFFFFFF);
    check("sltu", alu_result, 32'h1); check_comb(); tick();
    drive(0, 0, 0, 6'h00, 6'h2A, 0, 0, 0, 1, 32'hFFFFFFFF);
    check("slt", alu_result, 32'h0); check_comb(); tick();
    drive(0, 0, 0, 6'h0F, 0, 0, 0, 16'h1234, 0, 0);
    check("lui", alu_result, 32'h12340000); check_comb(); tick();
    drive(0, 0, 0, 6'h0D, 0, 0, 0, 16'h8000, 0, 0);
    check("ori_zext", alu_result, 32'h00008000); check_comb(); tick();

    // Multiply / divide
    run(0, 1, 32'hBFC00000, 6'h00, 6'h18, 0, 0, 0, 32'hFFFFFFFF, 2);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);
    run(0, 1, 32'hBFC00000, 6'h00, 6'h1A, 0, 0, 0, 32'hFFFFFFF9, 2);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    run(0, 1, 32'hBFC00000, 6'h00, 6'h1B, 0, 0, 0, 32'h12345678, 0);
    check("divu0_hi", hi, 32'hFFFFFFFF);
    check("divu0_lo", lo, 32'hFFFFFFFD);
    run(0, 0, 32'hBFC00000, 6'h00, 6'h18, 0, 0, 0, 32'h3, 32'h3);
    check("mult_gated", lo, 32'hFFFFFFFD);

    // MTHI / MFHI, reset discarding a pending update, MFLO after reset
    run(0, 1, 32'hBFC00000, 6'h00, 6'h11, 0, 0, 0, 32'hDEADBEEF, 0);
    check("mthi", hi, 32'hDEADBEEF);
    drive(0, 1, 32'hBFC00000, 6'h00, 6'h10, 0, 0, 0, 0, 0);
    check("mfhi", alu_result, 32'hDEADBEEF); check_comb(); tick();
    run(1, 1, 32'h0, 6'h00, 6'h18, 0, 0, 0, 32'h7, 32'h9);
    check("reset_discard_lo", lo, 32'h0);
    drive(0, 1, 32'hBFC00010, 6'h00, 6'h12, 0, 0, 0, 0, 0);
    check("mflo_reset", alu_result, 32'h0); check_comb(); tick();

    // REGIMM and link
    drive(0, 0, 0, 6'h01, 0, 0, 5'h01, 16'h0, 0, 0);
    check("bgez_zero", 32'(branch_taken), 32'h1); check_comb(); tick();
    drive(0, 0, 0, 6'h01, 0, 0, 5'h00, 16'h0, 0, 0);
    check("bltz_zero", 32'(branch_taken), 32'h0); check_comb(); tick();
    drive(0, 0, 0, 6'h03, 0, 0, 0, 16'h0, 0, 0);
    check("jal_link", alu_result, 32'hBFC00018); check_comb(); tick();

    // Randomized mix against the model
    for (int i = 0; i < 600; i++) begin
      rs  = pick_val();
      rt  = ($urandom_range(0, 4) == 0) ? rs : pick_val();
      fn  = 6'($urandom);
      rtf = 5'($urandom);
      case ($urandom_range(0, 9))
        0: op = 6'($urandom);
        1, 2, 3, 4: begin op = 6'h00; fn = r_fn[$urandom_range(0, 22)]; end
        default: op = i_op[$urandom_range(0, 20)];
      endcase
      if (op == 6'h01 && $urandom_range(0, 3) != 0) rtf = rim[$urandom_range(0, 3)];
      run(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) != 0), $urandom,
          op, fn, 5'($urandom), rtf, 16'($urandom), rs, rt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
